stream_out_bridge: RTL and testbench

- Bus-to-stream bridge: the opposite direction of the stream-to-bus capture path in the audio_out subsystem.
- The CPU writes audio sample words over the simple slave bus into an internal DEPTH × DATA_SIZE FIFO.
- The block presents those words to a downstream stream sink (codec serializer) with a valid/ready handshake.
- Provides status, control, underrun accounting and a low-watermark interrupt so software can keep the FIFO fed.

---
 rtl/stream_out_pkg.sv | 27 ++
 rtl/sync_fifo_ram.sv | 57 +++++
 rtl/stream_out_bridge.sv | 223 ++++++++++++++++++++++
 tb/tb_stream_out_bridge.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_out_pkg.sv
// Shared definitions for the audio_out bus-to-stream bridge.
// Register map, CTRL/STATUS bit positions and the underrun counter width.
package stream_out_pkg;

  typedef enum logic [1:0] {
    REG_DATA     = 2'd0,
    REG_STATUS   = 2'd1,
    REG_CTRL     = 2'd2,
    REG_UNDERRUN = 2'd3
  } reg_addr_e;

  // CTRL write fields; flush and clear_sticky are one-shot strobes.
  localparam int unsigned CTRL_ENABLE     = 0;
  localparam int unsigned CTRL_FLUSH      = 1;
  localparam int unsigned CTRL_IRQ_EN     = 2;
  localparam int unsigned CTRL_CLR_STICKY = 3;

  // STATUS read fields (level occupies the low bits).
  localparam int unsigned STAT_EMPTY    = 16;
  localparam int unsigned STAT_FULL     = 17;
  localparam int unsigned STAT_OVERFLOW = 18;
  localparam int unsigned STAT_UNDERRUN = 19;
  localparam int unsigned STAT_ENABLE   = 20;

  localparam int unsigned UND_CNT_W = 16;

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x DATA_SIZE sample storage with write/read pointers and a
// synchronous read port. rd_data updates only on rd_en and holds otherwise,
// so it doubles as the first pipeline stage in front of the output register.
// Occupancy is tracked by the owner; this block never checks full/empty.
// Ports:
//   clk, rst      clock, synchronous active-high reset (pointers only)
//   flush         return both pointers to zero
//   wr_en/wr_data write one word at wr_ptr
//   rd_en/rd_data read word at rd_ptr, available the cycle after rd_en
module sync_fifo_ram #(
  parameter int unsigned DATA_SIZE  = 28,
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 wr_en,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  output logic [DATA_SIZE-1:0] rd_data
);

  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_SIZE-1:0]  mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/stream_out_bridge.sv
// Bus-to-stream bridge: CPU pushes audio samples through the slave bus into
// a FIFO; words are presented to the codec serializer on a valid/ready
// stream. Provides status, control, underrun accounting and a low-watermark
// interrupt.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   chipselect/address/read/write/writedata/read_data
//                            slave bus; 0=DATA 1=STATUS 2=CTRL 3=UNDERRUN,
//                            read_data registered with 1-cycle latency
//   sink_valid/sink_data/sink_ready
//                            output stream, sink_data registered
//   irq                      level-sensitive low-watermark interrupt
module stream_out_bridge
  import stream_out_pkg::*;
#(
  parameter int unsigned DATA_SIZE  = 28,
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned LOW_WATER  = 512
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 chipselect,
  input  logic [1:0]           address,
  input  logic                 read,
  input  logic                 write,
  input  logic [31:0]          writedata,
  output logic [31:0]          read_data,
  output logic                 sink_valid,
  output logic [DATA_SIZE-1:0] sink_data,
  input  logic                 sink_ready,
  output logic                 irq
);

  localparam logic [ADDR_WIDTH:0]  DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]  LOW_L   = (ADDR_WIDTH + 1)'(LOW_WATER);
  localparam logic [ADDR_WIDTH:0]  LVL_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [UND_CNT_W-1:0] UND_ONE = {{(UND_CNT_W-1){1'b0}}, 1'b1};

  reg_addr_e reg_addr;
  logic      wr_data_reg, wr_ctrl_reg, wr_und_reg, bus_rd;
  logic      flush, clr_sticky;

  logic [ADDR_WIDTH:0] level, level_nxt, staged;
  logic                full, empty, push, pop;
  logic                ram_has_word, rd_issue, s1_valid, s1_move;
  logic [DATA_SIZE-1:0] ram_rd_data;

  logic                 out_valid;
  logic [DATA_SIZE-1:0] out_data;

  logic                 ctrl_enable, ctrl_irq_en;
  logic                 ovf_flag, und_flag, und_inc;
  logic [UND_CNT_W-1:0] und_cnt;
  logic                 irq_q;
  logic [31:0]          status_word, rd_mux, rd_q;

  // ---------------- bus decode ----------------
  assign reg_addr    = reg_addr_e'(address);
  assign wr_data_reg = chipselect & write & (reg_addr == REG_DATA);
  assign wr_ctrl_reg = chipselect & write & (reg_addr == REG_CTRL);
  assign wr_und_reg  = chipselect & write & (reg_addr == REG_UNDERRUN);
  assign bus_rd      = chipselect & read;
  assign flush       = wr_ctrl_reg & writedata[CTRL_FLUSH];
  assign clr_sticky  = wr_ctrl_reg & writedata[CTRL_CLR_STICKY];

  if (DATA_SIZE < 32) begin : g_wd_unused
    logic unused_wd_hi;
    assign unused_wd_hi = &{1'b0, writedata[31:DATA_SIZE]};
  end

  // ---------------- occupancy ----------------
  assign full  = (level == DEPTH_L);
  assign empty = (level == '0);
  assign push  = wr_data_reg & ~full;
  assign pop   = out_valid & sink_ready;

  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + LVL_ONE;
      2'b01:   level_nxt = level - LVL_ONE;
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      level <= '0;
    end else begin
      level <= level_nxt;
    end
  end

  // ---------------- read pipeline ----------------
  // level includes the RAM read stage (s1) and the output register, so the
  // RAM still holds an unread word only when level exceeds those two.
  assign staged       = {{ADDR_WIDTH{1'b0}}, s1_valid} + {{ADDR_WIDTH{1'b0}}, out_valid};
  assign ram_has_word = (level > staged);
  assign s1_move      = s1_valid & ctrl_enable & (~out_valid | sink_ready);
  assign rd_issue     = ctrl_enable & ram_has_word & (~s1_valid | s1_move);

  sync_fifo_ram #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .wr_en  (push),
    .wr_data(writedata[DATA_SIZE-1:0]),
    .rd_en  (rd_issue),
    .rd_data(ram_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      s1_valid <= 1'b0;
    end else if (rd_issue) begin
      s1_valid <= 1'b1;
    end else if (s1_move) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s1_move) begin
      out_valid <= 1'b1;
      out_data  <= ram_rd_data;
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end

  assign sink_valid = out_valid;
  assign sink_data  = out_data;

  // ---------------- control and sticky state ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_enable <= 1'b0;
      ctrl_irq_en <= 1'b0;
    end else if (wr_ctrl_reg) begin
      ctrl_enable <= writedata[CTRL_ENABLE];
      ctrl_irq_en <= writedata[CTRL_IRQ_EN];
    end
  end

  assign und_inc = ctrl_enable & sink_ready & ~out_valid;

  always_ff @(posedge clk) begin
    if (rst || clr_sticky) begin
      ovf_flag <= 1'b0;
      und_flag <= 1'b0;
    end else begin
      if (wr_data_reg && full) begin
        ovf_flag <= 1'b1;
      end
      if (und_inc) begin
        und_flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || wr_und_reg) begin
      und_cnt <= '0;
    end else if (und_inc && (und_cnt != '1)) begin
      und_cnt <= und_cnt + UND_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= ctrl_irq_en & ctrl_enable & (level < LOW_L);
    end
  end

  assign irq = irq_q;

  // ---------------- register read ----------------
  always_comb begin
    status_word                 = '0;
    status_word[ADDR_WIDTH:0]   = level;
    status_word[STAT_EMPTY]     = empty;
    status_word[STAT_FULL]      = full;
    status_word[STAT_OVERFLOW]  = ovf_flag;
    status_word[STAT_UNDERRUN]  = und_flag;
    status_word[STAT_ENABLE]    = ctrl_enable;
  end

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      REG_STATUS: rd_mux = status_word;
      REG_CTRL: begin
        rd_mux[CTRL_ENABLE] = ctrl_enable;
        rd_mux[CTRL_IRQ_EN] = ctrl_irq_en;
      end
      REG_UNDERRUN: rd_mux[UND_CNT_W-1:0] = und_cnt;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else if (bus_rd) begin
      rd_q <= rd_mux;
    end
  end

  assign read_data = rd_q;

endmodule

// File: tb/tb_stream_out_bridge.sv
module tb_stream_out_bridge;

  localparam int unsigned DS    = 28;
  localparam int unsigned DEPTH = 2048;
  localparam int unsigned LOW   = 512;

  logic          clk;
  logic          rst;
  logic          chipselect;
  logic [1:0]    address;
  logic          read;
  logic          write;
  logic [31:0]   writedata;
  logic [31:0]   read_data;
  logic          sink_valid;
  logic [DS-1:0] sink_data;
  logic          sink_ready;
  logic          irq;

  stream_out_bridge #(
    .DATA_SIZE(DS),
    .DEPTH    (DEPTH),
    .LOW_WATER(LOW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .chipselect(chipselect),
    .address   (address),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .read_data (read_data),
    .sink_valid(sink_valid),
    .sink_data (sink_data),
    .sink_ready(sink_ready),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: queue of accepted words, control/sticky state,
  // expected register read value and expected irq.
  logic [DS-1:0] mq[$];
  bit            m_en, m_irqen, m_ovf, m_und, m_irq, hold_prev;
  int unsigned   m_cnt;
  logic [31:0]   m_rd;
  logic [DS-1:0] hold_data, last_pop;
  int            pops = 0;

  task automatic model_step();
    int          lvl;
    bit          wr, rd, fl;
    logic [31:0] st;
    lvl = mq.size();
    if (rst) begin
      mq.delete();
      m_en = 0; m_irqen = 0; m_ovf = 0; m_und = 0; m_irq = 0;
      m_cnt = 0; m_rd = '0; hold_prev = 0;
    end else begin
      wr = chipselect && write;
      rd = chipselect && read;
      fl = wr && (address == 2'd2) && writedata[1];
      if (hold_prev) begin
        check("hold_valid", 32'(sink_valid), 32'd1);
        check("hold_data", 32'(sink_data), 32'(hold_data));
      end
      check("irq", 32'(irq), 32'(m_irq));
      hold_prev = sink_valid && !sink_ready && !fl;
      hold_data = sink_data;
      if (rd) begin
        st = '0;
        st[11:0] = lvl[11:0];
        st[16] = (lvl == 0);
        st[17] = (lvl == DEPTH);
        st[18] = m_ovf;
        st[19] = m_und;
        st[20] = m_en;
        case (address)
          2'd0: m_rd = '0;
          2'd1: m_rd = st;
          2'd2: m_rd = {29'd0, m_irqen, 1'b0, m_en};
          default: m_rd = {16'd0, m_cnt[15:0]};
        endcase
      end
      m_irq = m_irqen && m_en && (lvl < LOW);
      if (m_en && sink_ready && !sink_valid) begin
        m_und = 1;
        if (m_cnt < 65535) m_cnt++;
      end
      if (sink_valid && sink_ready) begin
        if (mq.size() == 0) begin
          check("sb_nonempty", 32'(mq.size()), 32'd1);
        end else begin
          check("sink_data", 32'(sink_data), 32'(mq[0]));
          void'(mq.pop_front());
        end
        last_pop = sink_data;
        pops++;
      end
      if (wr) begin
        case (address)
          2'd0: begin
            if (lvl == DEPTH) m_ovf = 1;
            else mq.push_back(writedata[DS-1:0]);
          end
          2'd2: begin
            if (writedata[3]) begin m_ovf = 0; m_und = 0; end
            m_en    = writedata[0];
            m_irqen = writedata[2];
            if (writedata[1]) mq.delete();
          end
          2'd3: m_cnt = 0;
          default: ;
        endcase
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input string tag);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    check(tag, read_data, m_rd);
  endtask

  task automatic push_words(input int n, input int base);
    chipselect = 1'b1; write = 1'b1; read = 1'b0; address = 2'd0;
    for (int i = 0; i < n; i++) begin
      writedata = 32'(base + i);
      @(negedge clk);
    end
    chipselect = 1'b0; write = 1'b0;
  endtask

  initial begin
    int p0;
    int cycles;
    int op;
    bit was_rd;
    rst = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = 2'd0; writedata = '0; sink_ready = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_read_data", read_data, 32'd0);
    check("rst_sink_valid", 32'(sink_valid), 32'd0);
    check("rst_sink_data", 32'(sink_data), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    bus_read(2'd1, "t0_status");
    check("t0_status_const", read_data, 32'h0001_0000);
    bus_read(2'd2, "t0_ctrl");
    bus_read(2'd3, "t0_underrun");
    bus_read(2'd0, "t0_data");

    // first-word latency and back-to-back flow
    sink_ready = 1'b1;
    bus_write(2'd2, 32'h1);
    chipselect = 1'b1; write = 1'b1; address = 2'd0; writedata = 32'd1;
    @(negedge clk); check("t1_lat0", 32'(sink_valid), 32'd0);
    writedata = 32'd2;
    @(negedge clk); check("t1_lat1", 32'(sink_valid), 32'd0);
    writedata = 32'd3;
    @(negedge clk);
    check("t1_valid", 32'(sink_valid), 32'd1);
    check("t1_d1", 32'(sink_data), 32'd1);
    chipselect = 1'b0; write = 1'b0;
    @(negedge clk); check("t1_d2", 32'(sink_data), 32'd2);
    check("t1_v2", 32'(sink_valid), 32'd1);
    @(negedge clk); check("t1_d3", 32'(sink_data), 32'd3);
    @(negedge clk); check("t1_idle", 32'(sink_valid), 32'd0);
    bus_read(2'd1, "t1_status");
    check("t1_level", 32'(read_data[11:0]), 32'd0);
    check("t1_empty", 32'(read_data[16]), 32'd1);

    // backpressure: word held stable, upper write bits ignored
    sink_ready = 1'b0;
    bus_write(2'd0, 32'hF0AB_CDEF);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      check("t2_hold_v", 32'(sink_valid), 32'd1);
      check("t2_hold_d", 32'(sink_data), 32'h00AB_CDEF);
      @(negedge clk);
    end
    bus_read(2'd1, "t2_status");
    check("t2_level", 32'(read_data[11:0]), 32'd1);
    p0 = pops;
    sink_ready = 1'b1;
    @(negedge clk);
    check("t2_one_xfer", 32'(pops - p0), 32'd1);
    check("t2_valid_low", 32'(sink_valid), 32'd0);
    bus_read(2'd1, "t2_status_after");

    // fill to full with overflow, then drain
    bus_write(2'd2, 32'h0);
    push_words(DEPTH + 1, 0);
    bus_read(2'd1, "t3_status");
    check("t3_full", 32'(read_data[17]), 32'd1);
    check("t3_ovf", 32'(read_data[18]), 32'd1);
    check("t3_level", 32'(read_data[11:0]), 32'd2048);
    p0 = pops;
    bus_write(2'd2, 32'h1);
    cycles = 0;
    while (mq.size() != 0 && cycles < 3000) begin
      @(negedge clk);
      cycles++;
    end
    check("t3_drain_timeout", 32'(mq.size()), 32'd0);
    check("t3_rate", 32'(cycles <= 2052), 32'd1);
    repeat (5) @(negedge clk);
    check("t3_count", 32'(pops - p0), 32'd2048);
    check("t3_last", 32'(last_pop), 32'd2047);
    check("t3_valid_low", 32'(sink_valid), 32'd0);

    // underrun counting, clearing and saturation
    bus_write(2'd3, 32'h0);
    repeat (10) @(negedge clk);
    bus_read(2'd3, "t4_und10");
    check("t4_und10_const", 32'(read_data[15:0]), 32'd10);
    bus_read(2'd1, "t4_status");
    check("t4_und_flag", 32'(read_data[19]), 32'd1);
    bus_write(2'd2, 32'h8);
    bus_write(2'd3, 32'h0);
    bus_read(2'd3, "t4_cleared");
    check("t4_cleared_const", 32'(read_data[15:0]), 32'd0);
    bus_read(2'd1, "t4_status_clr");
    check("t4_flag_clr", 32'(read_data[19]), 32'd0);
    bus_write(2'd2, 32'h1);
    repeat (70000) @(negedge clk);
    bus_read(2'd3, "t4_sat");
    check("t4_sat_const", 32'(read_data[15:0]), 32'hFFFF);

    // low-watermark irq
    bus_write(2'd2, 32'h0);
    sink_ready = 1'b0;
    bus_write(2'd2, 32'h5);
    push_words(511, 100);
    repeat (3) @(negedge clk);
    check("t5_irq_high", 32'(irq), 32'd1);
    bus_read(2'd1, "t5_status");
    check("t5_level511", 32'(read_data[11:0]), 32'd511);
    bus_write(2'd0, 32'h55);
    check("t5_irq_lag", 32'(irq), 32'd1);
    @(negedge clk);
    check("t5_irq_low", 32'(irq), 32'd0);

    // flush
    bus_write(2'd2, 32'h7);
    check("t6_flush_valid", 32'(sink_valid), 32'd0);
    bus_read(2'd1, "t6_status");
    check("t6_level0", 32'(read_data[11:0]), 32'd0);
    push_words(100, 7000);
    repeat (3) @(negedge clk);
    check("t6_valid_before", 32'(sink_valid), 32'd1);
    bus_read(2'd1, "t6_status100");
    check("t6_level100", 32'(read_data[11:0]), 32'd100);
    bus_write(2'd2, 32'h7);
    check("t6_flush2_valid", 32'(sink_valid), 32'd0);
    bus_read(2'd1, "t6_status_after");
    check("t6_empty", 32'(read_data[16]), 32'd1);

    // randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      sink_ready = ($urandom_range(0, 3) != 0);
      op = $urandom_range(0, 15);
      was_rd = 0;
      chipselect = 1'b1;
      if (op < 8) begin
        write = 1'b1; address = 2'd0; writedata = $urandom;
      end else if (op < 11) begin
        read = 1'b1; address = 2'(op - 7); was_rd = 1;
      end else if (op == 11) begin
        write = 1'b1; address = 2'd2;
        writedata = 32'($urandom_range(0, 15)) | 32'($urandom_range(0, 3) != 0);
      end else if (op == 12) begin
        write = 1'b1; address = 2'd3; writedata = $urandom;
      end else if (op == 13) begin
        write = 1'b1; address = 2'd1; writedata = $urandom;
      end else begin
        chipselect = 1'b0;
      end
      @(negedge clk);
      chipselect = 1'b0; write = 1'b0; read = 1'b0;
      if (was_rd) check("rnd_read", read_data, m_rd);
    end
    sink_ready = 1'b1;
    bus_write(2'd2, 32'h1);
    cycles = 0;
    while (mq.size() != 0 && cycles < 4000) begin
      @(negedge clk);
      cycles++;
    end
    check("rnd_drain_timeout", 32'(mq.size()), 32'd0);
    repeat (4) @(negedge clk);
    check("rnd_valid_low", 32'(sink_valid), 32'd0);
    bus_read(2'd1, "rnd_status");

    // reset mid-stream
    sink_ready = 1'b0;
    push_words(50, 300);
    repeat (3) @(negedge clk);
    bus_read(2'd1, "t8_status_pre");
    sink_ready = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t8_read_data", read_data, 32'd0);
    check("t8_sink_valid", 32'(sink_valid), 32'd0);
    check("t8_sink_data", 32'(sink_data), 32'd0);
    check("t8_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    bus_read(2'd1, "t8_status");
    check("t8_status_const", read_data, 32'h0001_0000);
    bus_read(2'd3, "t8_underrun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
